mc_control: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder.
- Moore FSM sequencing each MIPS instruction over FETCH/DECODE/EXEC/MEM/WB states, driving datapath selects and enables one state at a time.
- Generalised with parametrised ALUOp width, parametrised memory wait states, half-word load flags, jump support and illegal-opcode flagging.
- Sits between the instruction register opcode field and the shared multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers).

---
 rtl/mc_control_pkg.sv | 59 +++++
 rtl/mc_wait_counter.sv | 35 +++
 rtl/mc_control.sv | 174 +++++++++++++++++
 tb/tb_mc_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes, select values.
// Constants only; no timing or flow control of its own.
package mc_control_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_IMMEX  = 4'd9;
    localparam logic [3:0] ST_IMMWB  = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_MEMADR = ST_MEMADR,
        S_MEMRD  = ST_MEMRD,
        S_MEMWB  = ST_MEMWB,
        S_MEMWR  = ST_MEMWR,
        S_EXEC   = ST_EXEC,
        S_RWB    = ST_RWB,
        S_BRANCH = ST_BRANCH,
        S_IMMEX  = ST_IMMEX,
        S_IMMWB  = ST_IMMWB,
        S_JUMP   = ST_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_LH) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait-state counter shared by FETCH/MEMRD/MEMWR; done on the last held cycle.
// Counts only while enabled, clears on done, clear or reset; no backpressure.
module mc_wait_counter #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = done_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Moore FSM sequencing a multi-cycle MIPS datapath, one state's selects/enables at a time.
// Memory states hold MEM_LATENCY cycles; Illegal is the only output that looks at Opcode directly.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] Opcode,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                LoadHalf,
    output logic                LoadUnsigned,
    output logic                Illegal,
    output logic [3:0]          State
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic       half_q, half_d;
    logic       uns_q, uns_d;
    logic       wait_en;
    logic       wait_done;
    logic [5:0] op_in;

    assign op_in = 6'(Opcode);
    assign wait_en = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    mc_wait_counter #(
        .CNT_W (CNT_W),
        .LIMIT (MEM_LATENCY)
    ) u_wait (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (wait_en),
        .clr_i  (!wait_en),
        .done_o (wait_done)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        half_d      = half_q;
        uns_d       = uns_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b1;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_W'(ALUOP_ADD);
        PCSource    = PCSRC_ALU;
        Illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (wait_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB  = SRCB_IMM_SH2;
                opcode_d = op_in;
                half_d   = (op_in == OP_LH) || (op_in == OP_LHU);
                uns_d    = (op_in == OP_LHU);
                if (op_in == OP_RTYPE)      state_d = S_EXEC;
                else if (is_mem_op(op_in))  state_d = S_MEMADR;
                else if (op_in == OP_BEQ)   state_d = S_BRANCH;
                else if (op_in == OP_ADDI)  state_d = S_IMMEX;
                else if (op_in == OP_J)     state_d = S_JUMP;
                else begin
                    Illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                // Direction comes from the opcode captured in DECODE, not the live IR field.
                state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (wait_done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b0;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (wait_done) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(ALUOP_FUNCT);
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_W'(ALUOP_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_d     = S_FETCH;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            half_q   <= 1'b0;
            uns_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            half_q   <= half_d;
            uns_q    <= uns_d;
        end
    end

    assign LoadHalf     = half_q;
    assign LoadUnsigned = uns_q;
    assign State        = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control at memory latencies 1, 3 and 4.
module tb_mc_control;
    import mc_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] pcs;
        logic lh, lu, ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_v [3];
    logic [5:0] op_v  [3];
    logic       pcw [3], pcwc [3], iord [3], mrd [3], mwr [3], irw [3], m2r [3];
    logic       rdst [3], rw [3], asa [3], lh [3], lu [3], ill [3];
    logic [1:0] asb [3], aop [3], pcs [3];
    logic [3:0] st [3];

    int   vectors = 0;
    int   miscompares = 0;
    ctl_t sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control #(
            .OPCODE_W    (6),
            .ALUOP_W     (2),
            .MEM_LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4)),
            .CNT_W       (4)
        ) u_dut (
            .clk          (clk),
            .rst          (rst_v[g]),
            .Opcode       (op_v[g]),
            .PCWrite      (pcw[g]),
            .PCWriteCond  (pcwc[g]),
            .IorD         (iord[g]),
            .MemRead      (mrd[g]),
            .MemWrite     (mwr[g]),
            .IRWrite      (irw[g]),
            .MemtoReg     (m2r[g]),
            .RegDst       (rdst[g]),
            .RegWrite     (rw[g]),
            .ALUSrcA      (asa[g]),
            .ALUSrcB      (asb[g]),
            .ALUOp        (aop[g]),
            .PCSource     (pcs[g]),
            .LoadHalf     (lh[g]),
            .LoadUnsigned (lu[g]),
            .Illegal      (ill[g]),
            .State        (st[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t get_obs(input int i);
        ctl_t o;
        o = '{st: st[i], pcw: pcw[i], pcwc: pcwc[i], iord: iord[i], mrd: mrd[i], mwr: mwr[i],
              irw: irw[i], m2r: m2r[i], rdst: rdst[i], rw: rw[i], asa: asa[i], asb: asb[i],
              aop: aop[i], pcs: pcs[i], lh: lh[i], lu: lu[i], ill: ill[i]};
        return o;
    endfunction

    // Expected control word per state, written from the state table.
    task automatic push_rec(input logic [3:0] s, input bit last, input bit illg,
                            input bit h, input bit u);
        ctl_t e;
        e = '0;
        e.st  = s;
        e.m2r = 1'b1;
        case (s)
            ST_FETCH:  begin e.mrd = 1; e.asb = 2'd1; e.irw = last; e.pcw = last; end
            ST_DECODE: begin e.asb = 2'd3; e.ill = illg; end
            ST_MEMADR: begin e.asa = 1; e.asb = 2'd2; end
            ST_MEMRD:  begin e.mrd = 1; e.iord = 1; e.lh = h; e.lu = u; end
            ST_MEMWB:  begin e.rw = 1; e.m2r = 0; e.lh = h; e.lu = u; end
            ST_MEMWR:  begin e.mwr = 1; e.iord = 1; end
            ST_EXEC:   begin e.asa = 1; e.aop = 2'd2; end
            ST_RWB:    begin e.rw = 1; e.rdst = 1; end
            ST_BRANCH: begin e.asa = 1; e.aop = 2'd1; e.pcwc = 1; e.pcs = 2'd1; end
            ST_IMMEX:  begin e.asa = 1; e.asb = 2'd2; end
            ST_IMMWB:  begin e.rw = 1; end
            ST_JUMP:   begin e.pcw = 1; e.pcs = 2'd2; end
            default:   ;
        endcase
        sb.push_back(e);
    endtask

    task automatic push_instr(input int lat, input logic [5:0] op);
        bit h, u, illg;
        h = (op == 6'h21) || (op == 6'h25);
        u = (op == 6'h25);
        illg = !(op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h21, 6'h23, 6'h25, 6'h2B});
        for (int i = 0; i < lat; i++) push_rec(ST_FETCH, i == lat - 1, 0, h, u);
        push_rec(ST_DECODE, 0, illg, h, u);
        case (op)
            6'h00: begin push_rec(ST_EXEC, 0, 0, h, u); push_rec(ST_RWB, 0, 0, h, u); end
            6'h23, 6'h21, 6'h25: begin
                push_rec(ST_MEMADR, 0, 0, h, u);
                for (int i = 0; i < lat; i++) push_rec(ST_MEMRD, 0, 0, h, u);
                push_rec(ST_MEMWB, 0, 0, h, u);
            end
            6'h2B: begin
                push_rec(ST_MEMADR, 0, 0, h, u);
                for (int i = 0; i < lat; i++) push_rec(ST_MEMWR, 0, 0, h, u);
            end
            6'h04: push_rec(ST_BRANCH, 0, 0, h, u);
            6'h08: begin push_rec(ST_IMMEX, 0, 0, h, u); push_rec(ST_IMMWB, 0, 0, h, u); end
            6'h02: push_rec(ST_JUMP, 0, 0, h, u);
            default: ;
        endcase
    endtask

    // Called positioned #1 after the edge that entered the first expected state.
    task automatic drain(input int idx, input bit scramble);
        ctl_t e, o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = get_obs(idx);
            if (!(e.st == ST_MEMRD || e.st == ST_MEMWB)) begin
                o.lh = 1'b0;
                o.lu = 1'b0;
            end
            chk($sformatf("dut%0d st%0d", idx, e.st), 32'(o), 32'(e));
            if (scramble && e.st == ST_MEMADR) op_v[idx] = 6'h23;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int idx, input int lat, input logic [5:0] op, input bit scramble);
        op_v[idx] = op;
        push_instr(lat, op);
        drain(idx, scramble);
    endtask

    task automatic reset_inst(input int idx);
        rst_v[idx] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("dut%0d rst_state", idx), 32'(st[idx]), 32'(ST_FETCH));
        chk($sformatf("dut%0d rst_memwrite", idx), 32'(mwr[idx]), 32'd0);
        rst_v[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            op_v[i]  = 6'h00;
        end

        // Latency 1: every instruction class plus illegal and a live-opcode change.
        reset_inst(0);
        run(0, 1, OP_RTYPE, 0);
        run(0, 1, OP_LW, 0);
        run(0, 1, OP_SW, 1);
        run(0, 1, OP_BEQ, 0);
        run(0, 1, OP_J, 0);
        run(0, 1, 6'h3F, 0);
        run(0, 1, OP_LH, 0);
        run(0, 1, OP_ADDI, 0);
        run(0, 1, 6'h11, 0);
        run(0, 1, OP_LW, 0);

        // Latency 3: half-word flags and stretched memory states.
        reset_inst(1);
        run(1, 3, OP_LHU, 0);
        run(1, 3, OP_LH, 0);
        run(1, 3, OP_LW, 0);

        // Latency 4: reset in the middle of a store.
        reset_inst(2);
        op_v[2] = OP_SW;
        for (int i = 0; i < 4; i++) push_rec(ST_FETCH, i == 3, 0, 0, 0);
        push_rec(ST_DECODE, 0, 0, 0, 0);
        push_rec(ST_MEMADR, 0, 0, 0, 0);
        push_rec(ST_MEMWR, 0, 0, 0, 0);
        drain(2, 0);
        rst_v[2] = 1'b1;
        push_rec(ST_MEMWR, 0, 0, 0, 0);
        drain(2, 0);
        rst_v[2] = 1'b0;
        chk("dut2 post_rst_state", 32'(st[2]), 32'(ST_FETCH));
        chk("dut2 post_rst_memwrite", 32'(mwr[2]), 32'd0);
        run(2, 4, OP_RTYPE, 0);
        run(2, 4, OP_SW, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
